// File: rtl/dsm_pkg.sv
// dsm_pkg: shared definitions for the discard stage.
//   - MD field positions (next-module ID, discard flag, packet length)
//   - configuration packet framing, opcodes and response type
//   - register offsets relative to the configuration address base
//   - datapath FSM state encoding
package dsm_pkg;

    localparam int MD_W  = 256;
    localparam int PHV_W = 1024;
    localparam int CFG_W = 134;

    localparam int MD_MID_LO      = 80;
    localparam int MD_MID_HI      = 87;
    localparam int MD_DISCARD_BIT = 108;
    localparam int MD_LEN_LO      = 96;
    localparam int MD_LEN_HI      = 107;

    localparam logic [1:0] CFG_HEAD = 2'b01;
    localparam logic [1:0] CFG_TAIL = 2'b10;

    localparam logic [2:0] CFG_OP_WRITE  = 3'b010;
    localparam logic [2:0] CFG_OP_READ   = 3'b001;
    localparam logic [3:0] CFG_RESP_TYPE = 4'b1011;

    localparam logic [31:0] REG_DROP_EN      = 32'h0;
    localparam logic [31:0] REG_CLR          = 32'h1;
    localparam logic [31:0] REG_DROP_PKT_LO  = 32'h8;
    localparam logic [31:0] REG_DROP_PKT_HI  = 32'h9;
    localparam logic [31:0] REG_DROP_BYTE_LO = 32'hA;
    localparam logic [31:0] REG_DROP_BYTE_HI = 32'hB;
    localparam logic [31:0] REG_FWD_PKT_LO   = 32'hC;
    localparam logic [31:0] REG_FWD_PKT_HI   = 32'hD;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } dsm_state_e;

endpackage

// File: rtl/dsm_cfg_port.sv
// dsm_cfg_port: configuration packet chain port of the discard stage.
//   i_data/i_data_wr : incoming 134-bit config word and its valid
//   i_ready          : downstream ready; words are only taken while high
//   i_drop_pkt, i_drop_bytes, i_fwd_pkt : live counter values for reads
//   o_data/o_data_wr : registered outgoing word (zero when nothing sent)
//   o_drop_en        : discard enable register (resets to 1)
//   o_clr            : combinational counter-clear, same cycle as the word
// Local writes are consumed (head through tail); local counter reads turn
// the head into a response carrying the counter slice.
module dsm_cfg_port
    import dsm_pkg::*;
#(
    parameter logic [7:0]  LMID     = 8'd5,
    parameter logic [31:0] REG_BASE = 32'h5000_0000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [CFG_W-1:0]   i_data,
    input  logic               i_data_wr,
    input  logic               i_ready,
    input  logic [63:0]        i_drop_pkt,
    input  logic [63:0]        i_drop_bytes,
    input  logic [63:0]        i_fwd_pkt,
    output logic [CFG_W-1:0]   o_data,
    output logic               o_data_wr,
    output logic               o_drop_en,
    output logic               o_clr
);

    logic [CFG_W-1:0] r_data;
    logic             r_data_wr;
    logic             r_drop_en;
    logic             r_swallow;

    logic             w_take;
    logic             w_is_head;
    logic             w_is_tail;
    logic [2:0]       w_op;
    logic [7:0]       w_src;
    logic [7:0]       w_dst;
    logic [31:0]      w_off;
    logic             w_for_me;
    logic             w_wr_hit;
    logic             w_rd_hit;
    logic [31:0]      w_rd_val;
    logic [CFG_W-1:0] w_resp;

    assign w_take    = i_data_wr && i_ready;
    assign w_is_head = (i_data[133:132] == CFG_HEAD);
    assign w_is_tail = (i_data[133:132] == CFG_TAIL);
    assign w_op      = i_data[126:124];
    assign w_src     = i_data[111:104];
    assign w_dst     = i_data[103:96];
    assign w_off     = i_data[95:64] - REG_BASE;

    // Only a fresh head (not inside a swallowed packet) can be decoded.
    assign w_for_me = w_take && !r_swallow && w_is_head && (w_dst == LMID);
    assign w_wr_hit = w_for_me && (w_op == CFG_OP_WRITE) &&
                      ((w_off == REG_DROP_EN) || (w_off == REG_CLR));
    assign w_rd_hit = w_for_me && (w_op == CFG_OP_READ) &&
                      (w_off >= REG_DROP_PKT_LO) && (w_off <= REG_FWD_PKT_HI);

    // Combinational so the clear lands on the same edge as the word; the
    // counter logic gives it priority over any increment on that edge.
    assign o_clr = w_wr_hit && (w_off == REG_CLR) && i_data[0];

    always_comb begin
        w_rd_val = '0;
        case (w_off)
            REG_DROP_PKT_LO:  w_rd_val = i_drop_pkt[31:0];
            REG_DROP_PKT_HI:  w_rd_val = i_drop_pkt[63:32];
            REG_DROP_BYTE_LO: w_rd_val = i_drop_bytes[31:0];
            REG_DROP_BYTE_HI: w_rd_val = i_drop_bytes[63:32];
            REG_FWD_PKT_LO:   w_rd_val = i_fwd_pkt[31:0];
            REG_FWD_PKT_HI:   w_rd_val = i_fwd_pkt[63:32];
            default:          w_rd_val = '0;
        endcase
    end

    // Response head: type 1011 in [127:124], MIDs swapped, data = slice.
    always_comb begin
        w_resp           = i_data;
        w_resp[127:124]  = CFG_RESP_TYPE;
        w_resp[111:104]  = w_dst;
        w_resp[103:96]   = w_src;
        w_resp[31:0]     = w_rd_val;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data    <= '0;
            r_data_wr <= 1'b0;
            r_drop_en <= 1'b1;
            r_swallow <= 1'b0;
        end else begin
            r_data    <= '0;
            r_data_wr <= 1'b0;
            if (w_take) begin
                if (r_swallow) begin
                    if (w_is_tail) begin
                        r_swallow <= 1'b0;
                    end
                end else if (w_wr_hit) begin
                    r_swallow <= 1'b1;
                    if (w_off == REG_DROP_EN) begin
                        r_drop_en <= i_data[0];
                    end
                end else begin
                    r_data    <= w_rd_hit ? w_resp : i_data;
                    r_data_wr <= 1'b1;
                end
            end
        end
    end

    assign o_data    = r_data;
    assign o_data_wr = r_data_wr;
    assign o_drop_en = r_drop_en;

endmodule

// File: rtl/dsm_sa_fifo.sv
// dsm_sa_fifo: single-clock show-ahead FIFO.
//   i_clk, i_srst (synchronous flush), i_data/i_wrreq (write side),
//   i_rdreq (pop), o_q (current head, valid whenever !o_empty),
//   o_empty, o_usedw (occupancy, 0 .. 2**AW).
// Writes while full and reads while empty are ignored.
module dsm_sa_fifo #(
    parameter int W  = 256,
    parameter int AW = 8
) (
    input  logic          i_clk,
    input  logic          i_srst,
    input  logic [W-1:0]  i_data,
    input  logic          i_wrreq,
    input  logic          i_rdreq,
    output logic [W-1:0]  o_q,
    output logic          o_empty,
    output logic [AW:0]   o_usedw
);

    logic [W-1:0]  r_mem [2**AW];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;
    logic          w_full;
    logic          w_wr;
    logic          w_rd;

    // Occupancy can reach exactly 2**AW, so the top bit alone means full.
    assign w_full  = r_cnt[AW];
    assign o_empty = (r_cnt == '0);
    assign o_usedw = r_cnt;
    assign w_wr    = i_wrreq && !w_full;
    assign w_rd    = i_rdreq && !o_empty;
    assign o_q     = r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/fifo_1024_256.sv
// fifo_1024_256: 1024-bit wide, 256-deep show-ahead FIFO for PHVs.
//   i_clk, i_srst, i_data, i_wrreq, i_rdreq, o_q, o_empty, o_usedw.
module fifo_1024_256 (
    input  logic          i_clk,
    input  logic          i_srst,
    input  logic [1023:0] i_data,
    input  logic          i_wrreq,
    input  logic          i_rdreq,
    output logic [1023:0] o_q,
    output logic          o_empty,
    output logic [8:0]    o_usedw
);

    dsm_sa_fifo #(.W(1024), .AW(8)) u_fifo (
        .i_clk   (i_clk),
        .i_srst  (i_srst),
        .i_data  (i_data),
        .i_wrreq (i_wrreq),
        .i_rdreq (i_rdreq),
        .o_q     (o_q),
        .o_empty (o_empty),
        .o_usedw (o_usedw)
    );

endmodule

// File: rtl/fifo_256_256.sv
// fifo_256_256: 256-bit wide, 256-deep show-ahead FIFO for metadata.
//   i_clk, i_srst, i_data, i_wrreq, i_rdreq, o_q, o_empty, o_usedw.
module fifo_256_256 (
    input  logic         i_clk,
    input  logic         i_srst,
    input  logic [255:0] i_data,
    input  logic         i_wrreq,
    input  logic         i_rdreq,
    output logic [255:0] o_q,
    output logic         o_empty,
    output logic [8:0]   o_usedw
);

    dsm_sa_fifo #(.W(256), .AW(8)) u_fifo (
        .i_clk   (i_clk),
        .i_srst  (i_srst),
        .i_data  (i_data),
        .i_wrreq (i_wrreq),
        .i_rdreq (i_rdreq),
        .o_q     (o_q),
        .o_empty (o_empty),
        .o_usedw (o_usedw)
    );

endmodule

// File: rtl/dsm_discard_stage.sv
// dsm_discard_stage: executes the discard decision for local packets.
//   in_dsm_md/_wr, in_dsm_phv/_wr   : paired MD/PHV streams from upstream
//   out_dsm_md_alf, out_dsm_phv_alf : almost-full back to upstream
//   out_dsm_md/_wr, out_dsm_phv/_wr : paired streams to the next module
//   in_dsm_md_alf, in_dsm_phv_alf   : almost-full from the next module
//   cin_dsm_*/cout_dsm_*            : 134-bit configuration chain
//   o_dbg_state                     : datapath FSM state
//
// Handshake: *_wr is a one-cycle write strobe; the receiver must accept
// every strobed word. *_alf is advisory backpressure and only stops new
// packets from being launched. The config chain moves a word only in a
// cycle where both cin_dsm_data_wr and cin_dsm_ready are high.
module dsm_discard_stage
    import dsm_pkg::*;
#(
    parameter logic [7:0]  LMID       = 8'd5,
    parameter logic [7:0]  NMID       = 8'd6,
    parameter logic [31:0] REG_BASE   = 32'h5000_0000,
    parameter logic [7:0]  ALF_THRESH = 8'd250
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [MD_W-1:0]    in_dsm_md,
    input  logic               in_dsm_md_wr,
    output logic               out_dsm_md_alf,
    input  logic [PHV_W-1:0]   in_dsm_phv,
    input  logic               in_dsm_phv_wr,
    output logic               out_dsm_phv_alf,
    output logic [MD_W-1:0]    out_dsm_md,
    output logic               out_dsm_md_wr,
    input  logic               in_dsm_md_alf,
    output logic [PHV_W-1:0]   out_dsm_phv,
    output logic               out_dsm_phv_wr,
    input  logic               in_dsm_phv_alf,
    input  logic [CFG_W-1:0]   cin_dsm_data,
    input  logic               cin_dsm_data_wr,
    output logic               cout_dsm_ready,
    output logic [CFG_W-1:0]   cout_dsm_data,
    output logic               cout_dsm_data_wr,
    input  logic               cin_dsm_ready,
    output dsm_state_e         o_dbg_state
);

    dsm_state_e       r_state;
    dsm_state_e       w_state_nxt;

    logic             w_srst;
    logic [MD_W-1:0]  w_md_head;
    logic [PHV_W-1:0] w_phv_head;
    logic             w_md_empty;
    logic             w_phv_empty;
    logic [8:0]       w_md_usedw;
    logic [8:0]       w_phv_usedw;
    logic             w_rd;
    logic             w_is_local;
    logic             w_drop;
    logic [MD_W-1:0]  w_md_fwd;
    logic             w_drop_en;
    logic             w_clr;
    logic             w_alf;

    logic [MD_W-1:0]  r_out_md;
    logic [PHV_W-1:0] r_out_phv;
    logic             r_out_wr;
    logic [63:0]      r_drop_pkt;
    logic [63:0]      r_drop_bytes;
    logic [63:0]      r_fwd_pkt;

    assign w_srst = !rst_n;

    fifo_256_256 u_md_fifo (
        .i_clk   (clk),
        .i_srst  (w_srst),
        .i_data  (in_dsm_md),
        .i_wrreq (in_dsm_md_wr),
        .i_rdreq (w_rd),
        .o_q     (w_md_head),
        .o_empty (w_md_empty),
        .o_usedw (w_md_usedw)
    );

    fifo_1024_256 u_phv_fifo (
        .i_clk   (clk),
        .i_srst  (w_srst),
        .i_data  (in_dsm_phv),
        .i_wrreq (in_dsm_phv_wr),
        .i_rdreq (w_rd),
        .o_q     (w_phv_head),
        .o_empty (w_phv_empty),
        .o_usedw (w_phv_usedw)
    );

    dsm_cfg_port #(.LMID(LMID), .REG_BASE(REG_BASE)) u_cfg (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_data       (cin_dsm_data),
        .i_data_wr    (cin_dsm_data_wr),
        .i_ready      (cin_dsm_ready),
        .i_drop_pkt   (r_drop_pkt),
        .i_drop_bytes (r_drop_bytes),
        .i_fwd_pkt    (r_fwd_pkt),
        .o_data       (cout_dsm_data),
        .o_data_wr    (cout_dsm_data_wr),
        .o_drop_en    (w_drop_en),
        .o_clr        (w_clr)
    );

    assign cout_dsm_ready = cin_dsm_ready;

    // FIFO flush is synchronous, so occupancy is masked while in reset.
    assign w_alf = in_dsm_md_alf | in_dsm_phv_alf |
                   (w_md_usedw  > {1'b0, ALF_THRESH}) |
                   (w_phv_usedw > {1'b0, ALF_THRESH});
    assign out_dsm_md_alf  = rst_n & w_alf;
    assign out_dsm_phv_alf = rst_n & w_alf;

    // Classification of the head metadata.
    assign w_is_local = (w_md_head[MD_MID_HI:MD_MID_LO] == LMID);
    assign w_drop     = w_is_local && w_md_head[MD_DISCARD_BIT] && w_drop_en;

    always_comb begin
        w_md_fwd = w_md_head;
        if (w_is_local) begin
            w_md_fwd[MD_MID_HI:MD_MID_LO] = NMID;
            w_md_fwd[MD_DISCARD_BIT]      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Both FIFOs are popped together, which keeps MD/PHV pairing intact.
    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_md_empty && !w_phv_empty && !in_dsm_md_alf && !in_dsm_phv_alf) begin
                    w_rd        = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output registers load on the pop edge and are therefore valid during
    // SEND; every other cycle they are driven to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_md  <= '0;
            r_out_phv <= '0;
            r_out_wr  <= 1'b0;
        end else if (w_rd && !w_drop) begin
            r_out_md  <= w_md_fwd;
            r_out_phv <= w_phv_head;
            r_out_wr  <= 1'b1;
        end else begin
            r_out_md  <= '0;
            r_out_phv <= '0;
            r_out_wr  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_pkt   <= '0;
            r_drop_bytes <= '0;
            r_fwd_pkt    <= '0;
        end else if (w_clr) begin
            r_drop_pkt   <= '0;
            r_drop_bytes <= '0;
            r_fwd_pkt    <= '0;
        end else if (w_rd) begin
            if (w_drop) begin
                r_drop_pkt   <= r_drop_pkt + 64'd1;
                r_drop_bytes <= r_drop_bytes + {52'b0, w_md_head[MD_LEN_HI:MD_LEN_LO]};
            end else begin
                r_fwd_pkt    <= r_fwd_pkt + 64'd1;
            end
        end
    end

    assign out_dsm_md     = r_out_md;
    assign out_dsm_phv    = r_out_phv;
    assign out_dsm_md_wr  = r_out_wr;
    assign out_dsm_phv_wr = r_out_wr;
    assign o_dbg_state    = r_state;

endmodule

// File: doc/dsm_discard_stage.md
Name: dsm_discard_stage

Overview:
- Pipeline stage directly downstream of the statistics/counting module; consumes its paired MD (256b) and PHV (1024b) streams.
- Executes the discard decision carried in MD bit 108 for packets addressed to this stage, rewrites the next-module ID, and forwards everything else unchanged.
- Maintains 64-bit drop/forward counters, readable and clearable through the 134-bit configuration packet chain, which otherwise passes through with 1-cycle latency.

Parameters:
- LMID, 8'd5, local module ID matched against MD[87:80] and config dest MID [103:96].
- NMID, 8'd6, next module ID written into MD[87:80] on forwarded local packets.
- REG_BASE, 32'h50000000, config address base; register offsets 0x0–0xD below.
- ALF_THRESH, 8'd250, FIFO occupancy above which almost-full is raised.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_dsm_md  in  256  metadata from upstream.
- in_dsm_md_wr  in  1  MD write strobe.
- out_dsm_md_alf  out  1  MD almost-full to upstream.
- in_dsm_phv  in  1024  PHV from upstream.
- in_dsm_phv_wr  in  1  PHV write strobe.
- out_dsm_phv_alf  out  1  PHV almost-full to upstream.
- out_dsm_md  out  256  metadata to next module.
- out_dsm_md_wr  out  1  MD valid strobe.
- in_dsm_md_alf  in  1  downstream MD almost-full.
- out_dsm_phv  out  1024  PHV to next module.
- out_dsm_phv_wr  out  1  PHV valid strobe.
- in_dsm_phv_alf  in  1  downstream PHV almost-full.
- cin_dsm_data  in  134  config packet word.
- cin_dsm_data_wr  in  1  config word valid.
- cout_dsm_ready  out  1  equals cin_dsm_ready (combinational).
- cout_dsm_data  out  134  config word out.
- cout_dsm_data_wr  out  1  config word valid out.
- cin_dsm_ready  in  1  downstream config ready.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; all counters 0; drop_en=1; FIFOs flushed (srst = !rst_n).
- Buffering: MD FIFO 256x256 and PHV FIFO 1024x256, show-ahead, written by their strobes.
- out_dsm_md_alf = out_dsm_phv_alf = in_dsm_md_alf | in_dsm_phv_alf | md_usedw>ALF_THRESH | phv_usedw>ALF_THRESH.
- FSM IDLE:
  - Both FIFOs non-empty and neither downstream alf asserted: classify head MD, pulse rd on both FIFOs, go SEND.
  - Otherwise stay in IDLE; outputs are 0 and wr strobes are low.
- Classification:
  - MD[87:80]==LMID and MD[108]==1 and drop_en: drop. No output. drop_pkt+=1, drop_bytes+={52'b0, MD[107:96]}.
  - MD[87:80]==LMID otherwise: forward with MD[87:80]=NMID and MD[108]=0. fwd_pkt+=1.
  - Any other ID: bypass, MD unchanged. fwd_pkt+=1.
- FSM SEND: deassert rd. For non-drop, out_*_wr=1 for exactly one cycle, with MD and PHV presented in the same cycle. Return to IDLE.
- Timing: latency from FIFO head to output is 2 cycles; throughput is one packet per 2 cycles; MD/PHV pairing is never broken.
- Counters: 64-bit, wrap modulo 2^64.
- Config words: [133:132] 01=head, 10=tail, else body. Head fields: [126:124] op (010 write, 001 read), [103:96] dest MID, [111:104] src MID, [95:64] addr, [31:0] data.
- Write, dest==LMID, while cin_dsm_ready:
  - REG_BASE+0: drop_en <= data[0].
  - REG_BASE+1: data[0]=1 clears all counters.
  - Head and the following tail are swallowed (cout_dsm_data_wr=0).
- Read, dest==LMID, REG_BASE+8..+D (drop_pkt lo/hi, drop_bytes lo/hi, fwd_pkt lo/hi):
  - Emit head with [127:124]=4'b1011, src/dst MIDs swapped, [31:0]=counter slice; tail passed through.
  - Unknown address: word passed unchanged.
- All other words registered through with 1-cycle latency. When not ready, or when no word is valid, cout outputs are 0.
- Simultaneous events:
  - Clear and increment in the same cycle: clear wins, counter=0.
  - Read and increment in the same cycle: the pre-increment value is returned.
- Reset mid-packet: any partial output is abandoned, FIFO contents are lost, and the swallow flag is cleared.

Decomposition:
- Shared package dsm_pkg: MD field positions (MID 87:80, discard bit 108, length 107:96), config opcodes, response type 4'b1011, register offsets, FSM state encodings.
- Sub-module dsm_cfg_port holds the config pass-through, register decode and swallow flag, and outputs drop_en and clr. The datapath FSM and counters stay at top level; the FIFOs are fifo_256_256 and fifo_1024_256 instances.

Test Plan:
- MD ID=5, bit108=1, len=64, drop_en=1 -> no output; drop_pkt=1, drop_bytes=64; both FIFOs empty afterward.
- MD ID=5, bit108=0 -> output MD ID=6, bit108=0, PHV identical, 2 cycles after the FIFO has data; fwd_pkt=1.
- MD ID=3 -> MD/PHV bit-exact bypass; write REG_BASE+0 data=0, then MD ID=5 bit108=1 -> forwarded with ID=6, no drop counted.
- Hold in_dsm_md_alf=1 with 10 packets queued -> no out_wr; release -> 10 outputs in order at 2-cycle spacing; push 251 entries -> out_dsm_md_alf=1.
- After 3 drops, read REG_BASE+8 (src 1, dest 5) -> response [127:124]=1011, dst=1, src=5, [31:0]=3; write REG_BASE+1 data=1 -> head and tail swallowed; subsequent reads return 0.
- Clear issued in the same cycle as a drop -> drop_pkt=0; assert rst_n low mid-SEND -> outputs 0 next edge, FIFOs empty.
